lut_table_loader: RTL and testbench
===================================

Name: lut_table_loader

Overview:
- Write-side companion to the generated fixed-ROM neuron LUTs: a runtime-programmable truth-table neuron.
- Receives a packed truth-table stream over a valid/ready config port and writes it into a 2^IN_BITS x OUT_BITS distributed RAM.
- Once armed, serves registered lookups on the same M0/M1 data ports as a compiled neuron.
- Used for on-chip reprogramming of layer neurons without re-synthesis.

Parameters:
- IN_BITS, 6, neuron input (address) width; DEPTH = 2^IN_BITS entries.
- OUT_BITS, 1, neuron output width per entry.
- WORD_BITS, 8, config word width. WORD_BITS % OUT_BITS == 0 and (DEPTH*OUT_BITS) % WORD_BITS == 0 are required; violation is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  pulse: begin (re)load, invalidates table
- cfg_data  in  WORD_BITS  packed table entries
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a word this cycle
- cfg_done  out  1  level: table fully loaded and armed
- cfg_err  out  1  one-cycle pulse: cfg_valid while not in LOAD
- M0  in  IN_BITS  lookup address
- M0_valid  in  1  lookup request
- M1  out  OUT_BITS  lookup result
- M1_valid  out  1  M1 valid, one cycle per accepted lookup

Behaviour:
- Derived constants: EPW = WORD_BITS/OUT_BITS entries per word; NWORDS = DEPTH/EPW (8 at defaults). Word counter is clog2(NWORDS) bits; entry address = word_idx*EPW + slot.
- Reset (async assert, sync deassert handled upstream): state=IDLE, word counter=0; cfg_ready, cfg_done, cfg_err, M1, M1_valid = 0.
- RAM contents are not reset. cfg_done=0 forces a reload after any reset.
- FSM states are IDLE, LOAD, ARMED.
- IDLE: cfg_ready=0, lookups ignored. cfg_start -> LOAD.
- LOAD:
  - cfg_ready=1. A word is accepted when cfg_valid&&cfg_ready.
  - Slot s = cfg_data[s*OUT_BITS +: OUT_BITS] is written to entry word_idx*EPW + s. Slot 0 is the lowest address; all EPW entries are written in the accept cycle.
  - Word counter increments per accept.
  - On accepting word NWORDS-1: next cycle state=ARMED, cfg_done=1, cfg_ready=0, counter wraps to 0.
- ARMED: cfg_done=1. cfg_start -> LOAD, cfg_done=0 from the next cycle.
- cfg_start in any state (including mid-LOAD):
  - Counter is cleared to 0 and the FSM enters/stays in LOAD.
  - A cfg_valid in the same cycle is not accepted (start wins), and cfg_ready is 0 that cycle.
  - Entries already written are left stale until overwritten.
- cfg_valid while not in LOAD, and not masked by a same-cycle cfg_start, gives cfg_err=1 for exactly one cycle. The word is dropped.
- Lookup:
  - In ARMED, M0_valid=1 at cycle t gives M1 = table[M0] and M1_valid=1 at t+1. Latency is 1 cycle, throughput is 1 per cycle, and there is no backpressure.
  - M0_valid outside ARMED: M1_valid=0 next cycle, M1 holds its previous value.
  - M1 holds its value when M1_valid=0.
  - A lookup in the same cycle as cfg_start in ARMED is still served, with pre-reload contents.
- No read-during-write hazard exists, because lookups are only served in ARMED, where no writes occur.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 immediately. Check M0_valid=1 with M0=5 -> M1_valid stays 0.
- Full load, defaults: pulse cfg_start, stream words k=0..7 as 8'hA5^k with gaps on cfg_valid -> cfg_done=1 the cycle after the 8th accept, cfg_ready=0. Then check lookups:
  - M0=0 -> M1=1
  - M0=9 -> M1=0 (word 0xA4, bit 1)
  - M0=63 -> M1=1 (word 0xA2, bit 7)
  - Each result arrives 1 cycle later with M1_valid=1.
- Back-to-back lookups: M0 = 0,1,2,3 on consecutive cycles -> M1 = 1,0,1,0 on the following four cycles, with M1_valid continuously 1.
- Reload mid-LOAD: after 3 words, pulse cfg_start with cfg_valid=1 -> that word is not accepted and the counter restarts. Then stream 8 words of 8'hFF -> every address returns 1 and cfg_done asserts only after 8 new accepts.
- Protocol error: cfg_valid=1 in ARMED -> cfg_err pulses 1 cycle, table unchanged (M0=9 still returns 0), cfg_done stays 1.
- Reset mid-operation: rst during LOAD after 4 words -> cfg_done=0 and lookups are ignored. A fresh cfg_start plus 8 words is required to re-arm.

Source files
------------

// File: rtl/lut_table_loader.sv
// Runtime-programmable truth-table neuron.
// A packed truth table arrives over a valid/ready config port and is written
// into a 2^IN_BITS x OUT_BITS distributed RAM. Once the table is fully
// loaded (armed), the block answers M0/M1 lookups with one cycle of latency,
// exactly like a compiled fixed-ROM neuron.
module lut_table_loader #(
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1,
    parameter int WORD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [WORD_BITS-1:0] cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_done,
    output logic                 cfg_err,
    input  logic [IN_BITS-1:0]   M0,
    input  logic                 M0_valid,
    output logic [OUT_BITS-1:0]  M1,
    output logic                 M1_valid
);

    localparam int DEPTH  = 1 << IN_BITS;
    localparam int EPW    = WORD_BITS / OUT_BITS;   // entries per config word
    localparam int NWORDS = DEPTH / EPW;            // words per full table
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    // Reject geometries where the stream does not tile the table exactly.
    if (WORD_BITS % OUT_BITS != 0) begin : g_bad_slot
        $error("lut_table_loader: WORD_BITS must be a multiple of OUT_BITS");
    end
    if ((DEPTH * OUT_BITS) % WORD_BITS != 0) begin : g_bad_tile
        $error("lut_table_loader: table size must be a multiple of WORD_BITS");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    state_t                state;
    logic [CW-1:0]         wcnt;
    logic                  accept;
    logic                  last_word;
    logic                  lookup_go;
    logic [OUT_BITS-1:0]   mem [DEPTH];

    // A start pulse always wins over a same-cycle word, so ready is masked by it.
    assign cfg_ready = (state == LOAD) && !cfg_start;
    assign accept    = cfg_valid && cfg_ready;
    assign last_word = (wcnt == CW'(NWORDS - 1));
    // Lookups are served in ARMED only; this includes the cycle carrying a
    // reload start, which still sees the pre-reload contents.
    assign lookup_go = M0_valid && (state == ARMED);

    // Load sequencer: start/reload handling, word counting, arming, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && !cfg_start && (state != LOAD);
            if (cfg_start) begin
                state    <= LOAD;
                wcnt     <= '0;
                cfg_done <= 1'b0;
            end else if (accept) begin
                if (last_word) begin
                    state    <= ARMED;
                    wcnt     <= '0;
                    cfg_done <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    // Table write: every slot of an accepted word lands in the same cycle,
    // slot 0 at the lowest address. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int s = 0; s < EPW; s++) begin
                mem[IN_BITS'(int'(wcnt) * EPW + s)] <= cfg_data[s*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Registered lookup port; M1 holds its last value when no lookup is served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M1       <= '0;
            M1_valid <= 1'b0;
        end else begin
            M1_valid <= lookup_go;
            if (lookup_go) begin
                M1 <= mem[M0];
            end
        end
    end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed-plus-random bench for lut_table_loader at default parameters.
// A plain array holds the expected truth table; words are unpacked into it
// bit by bit as they are accepted, and lookups are compared against it.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic [5:0] M0 = '0;
    logic       M0_valid = 1'b0;
    logic [0:0] M1;
    logic       M1_valid;

    int   tests = 0;
    int   fails = 0;
    logic ref_tbl [64];

    lut_table_loader #(.IN_BITS(6), .OUT_BITS(1), .WORD_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .M0(M0), .M0_valid(M0_valid), .M1(M1), .M1_valid(M1_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word (after a random gap) and record it as table word k.
    task automatic send_word(input logic [7:0] w, input int k);
        repeat ($urandom_range(0, 2)) tick();
        cfg_valid = 1'b1;
        cfg_data  = w;
        #1;
        chk("ready_in_load", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        for (int s = 0; s < 8; s++) ref_tbl[k*8 + s] = w[s];
    endtask

    // Full load: start pulse then 8 words; done must rise only after the last.
    task automatic full_load(input logic [7:0] words [8]);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("done_clear_on_start", cfg_done, 0);
        for (int k = 0; k < 8; k++) begin
            chk("done_before_last", cfg_done, 0);
            send_word(words[k], k);
        end
        chk("done_after_last", cfg_done, 1);
        chk("ready_after_last", cfg_ready, 0);
    endtask

    task automatic lookup(input logic [5:0] a);
        M0 = a;
        M0_valid = 1'b1;
        tick();
        M0_valid = 1'b0;
        chk("lookup_valid", M1_valid, 1);
        chk($sformatf("lookup_data[%0d]", a), M1, ref_tbl[a]);
    endtask

    initial begin
        logic [7:0] words [8];
        logic [5:0] a;
        logic       old;

        // Asynchronous reset asserted mid-cycle clears outputs immediately.
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_m1", M1, 0);
        chk("rst_m1_valid", M1_valid, 0);
        tick();
        tick();
        rst = 1'b0;

        // Idle: lookups ignored, stray config word flagged.
        M0 = 6'd5;
        M0_valid = 1'b1;
        tick();
        M0_valid = 1'b0;
        chk("idle_lookup_ignored", M1_valid, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("idle_err_pulse", cfg_err, 1);
        tick();
        chk("idle_err_clear", cfg_err, 0);

        // Full load with 8'hA5^k.
        for (int k = 0; k < 8; k++) words[k] = 8'hA5 ^ 8'(k);
        full_load(words);
        lookup(6'd0);
        lookup(6'd9);
        lookup(6'd63);

        // Back-to-back lookups, then M1 hold.
        for (int i = 0; i < 4; i++) begin
            M0 = 6'(i);
            M0_valid = 1'b1;
            tick();
            chk("b2b_valid", M1_valid, 1);
            chk($sformatf("b2b_data[%0d]", i), M1, ref_tbl[i]);
        end
        M0_valid = 1'b0;
        tick();
        chk("hold_valid_low", M1_valid, 0);
        chk("hold_data", M1, ref_tbl[3]);

        // Protocol error while armed: word dropped, table intact.
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        tick();
        cfg_valid = 1'b0;
        chk("armed_err_pulse", cfg_err, 1);
        chk("armed_done_kept", cfg_done, 1);
        tick();
        chk("armed_err_clear", cfg_err, 0);
        lookup(6'd9);
        lookup(6'd8);

        // Reload aborted mid-LOAD; start wins over the same-cycle word.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) send_word(8'($urandom), k);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        #1;
        chk("start_masks_ready", cfg_ready, 0);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("reload_done_low", cfg_done, 0);
            send_word(8'hFF, k);
        end
        chk("reload_done", cfg_done, 1);
        for (int i = 0; i < 64; i++) lookup(6'(i));

        // Random full load and random lookups.
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        full_load(words);
        for (int i = 0; i < 16; i++) lookup(6'($urandom_range(0, 63)));

        // Lookup coinciding with reload start is served from old contents.
        a   = 6'($urandom_range(0, 63));
        old = ref_tbl[a];
        M0 = a;
        M0_valid  = 1'b1;
        cfg_start = 1'b1;
        tick();
        M0_valid  = 1'b0;
        cfg_start = 1'b0;
        chk("start_lookup_valid", M1_valid, 1);
        chk("start_lookup_data", M1, old);
        chk("start_done_low", cfg_done, 0);
        M0_valid = 1'b1;
        tick();
        M0_valid = 1'b0;
        chk("load_lookup_ignored", M1_valid, 0);

        // Reset in the middle of a load.
        for (int k = 0; k < 4; k++) send_word(8'(~ref_tbl[k*8]) ^ 8'($urandom), k);
        #2 rst = 1'b1;
        #1;
        chk("midrst_done", cfg_done, 0);
        chk("midrst_ready", cfg_ready, 0);
        tick();
        rst = 1'b0;
        M0 = 6'd0;
        M0_valid = 1'b1;
        tick();
        M0_valid = 1'b0;
        chk("midrst_lookup_ignored", M1_valid, 0);
        chk("midrst_done_still_low", cfg_done, 0);

        // Re-arm after reset.
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        full_load(words);
        lookup(6'd0);
        lookup(6'd63);
        for (int i = 0; i < 16; i++) lookup(6'($urandom_range(0, 63)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
